// File: rtl/reg_wb_arbiter_if.sv
// Writeback port bundle: two requesters, a hold input, and the registered
// register-file write port plus the conflict counter.
interface reg_wb_arbiter_if #(
   parameter int unsigned AW = 5,
   parameter int unsigned DW = 32,
   parameter int unsigned CW = 16
);
   logic          hold_i;
   logic          v0_i;
   logic [AW-1:0] a0_i;
   logic [DW-1:0] d0_i;
   logic          r0_o;
   logic          v1_i;
   logic [AW-1:0] a1_i;
   logic [DW-1:0] d1_i;
   logic          r1_o;
   logic          we_o;
   logic [AW-1:0] waddr_o;
   logic [DW-1:0] wdata_o;
   logic [CW-1:0] conflicts_o;

   modport slave (
      input  hold_i, v0_i, a0_i, d0_i, v1_i, a1_i, d1_i,
      output r0_o, r1_o, we_o, waddr_o, wdata_o, conflicts_o
   );

   modport master (
      output hold_i, v0_i, a0_i, d0_i, v1_i, a1_i, d1_i,
      input  r0_o, r1_o, we_o, waddr_o, wdata_o, conflicts_o
   );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Two-requester round-robin writeback arbiter for the register file.
// Grants are combinational; the write port and conflict counter are registered.
module reg_wb_arbiter #(
   parameter int unsigned AW = 5,
   parameter int unsigned DW = 32,
   parameter int unsigned CW = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   reg_wb_arbiter_if.slave       bus
);
   logic          prio_q, prio_d;
   logic          we_q, we_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [CW-1:0] conf_q, conf_d;
   logic          g0, g1;
   logic          conflict;

   always_comb begin
      // prio only matters when both requesters are valid
      g0       = !rst && !bus.hold_i && bus.v0_i && (!bus.v1_i || !prio_q);
      g1       = !rst && !bus.hold_i && bus.v1_i && (!bus.v0_i || prio_q);
      conflict = bus.v0_i && bus.v1_i && !bus.hold_i;
   end

   always_comb begin
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      prio_d  = prio_q;
      conf_d  = conf_q;
      if (g0) begin
         we_d    = (bus.a0_i != '0);
         waddr_d = bus.a0_i;
         wdata_d = bus.d0_i;
         prio_d  = 1'b1;
      end else if (g1) begin
         we_d    = (bus.a1_i != '0);
         waddr_d = bus.a1_i;
         wdata_d = bus.d1_i;
         prio_d  = 1'b0;
      end
      if (conflict && (conf_q != '1)) begin
         conf_d = conf_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_q  <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         conf_q  <= '0;
      end else begin
         prio_q  <= prio_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         conf_q  <= conf_d;
      end
   end

   assign bus.r0_o        = g0;
   assign bus.r1_o        = g1;
   assign bus.we_o        = we_q;
   assign bus.waddr_o     = waddr_q;
   assign bus.wdata_o     = wdata_q;
   assign bus.conflicts_o = conf_q;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: a per-cycle reference model plus literal
// spot checks; a second instance with a 4-bit counter covers saturation.
module tb_reg_wb_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   rst_cnt  = 0;

   reg_wb_arbiter_if #(.AW(5), .DW(32), .CW(16)) bus ();
   reg_wb_arbiter_if #(.AW(5), .DW(32), .CW(4))  bus4 ();

   reg_wb_arbiter #(.AW(5), .DW(32), .CW(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   reg_wb_arbiter #(.AW(5), .DW(32), .CW(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

   assign bus4.hold_i = bus.hold_i;
   assign bus4.v0_i   = bus.v0_i;
   assign bus4.a0_i   = bus.a0_i;
   assign bus4.d0_i   = bus.d0_i;
   assign bus4.v1_i   = bus.v1_i;
   assign bus4.a1_i   = bus.a1_i;
   assign bus4.d1_i   = bus.d1_i;

   always #5 clk = ~clk;

   always @(posedge rst) rst_cnt++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: spec-level state of the write port and counters.
   int          seen_cnt = 0;
   bit          m_prio;
   bit          m_we;
   int unsigned m_waddr, m_wdata, m_conf, m_conf4;

   always @(negedge clk) begin
      bit e0, e1;
      int unsigned addr, data;
      if (rst || rst_cnt != seen_cnt) begin
         m_prio = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_conf = 0; m_conf4 = 0;
         seen_cnt = rst_cnt;
      end
      if (rst) begin
         check("rst_we", 64'(bus.we_o), 64'(0));
         check("rst_waddr", 64'(bus.waddr_o), 64'(0));
         check("rst_wdata", 64'(bus.wdata_o), 64'(0));
         check("rst_conf", 64'(bus.conflicts_o), 64'(0));
         check("rst_grants", 64'({bus.r0_o, bus.r1_o}), 64'(0));
      end else begin
         check("m_we", 64'(bus.we_o), 64'(m_we));
         check("m_waddr", 64'(bus.waddr_o), 64'(m_waddr));
         check("m_wdata", 64'(bus.wdata_o), 64'(m_wdata));
         check("m_conf", 64'(bus.conflicts_o), 64'(m_conf));
         check("m_conf4", 64'(bus4.conflicts_o), 64'(m_conf4));
         e0 = 0; e1 = 0;
         if (!bus.hold_i) begin
            if (bus.v0_i && bus.v1_i) begin
               if (m_prio) e1 = 1; else e0 = 1;
            end else begin
               e0 = bus.v0_i;
               e1 = bus.v1_i;
            end
         end
         check("m_r0", 64'(bus.r0_o), 64'(e0));
         check("m_r1", 64'(bus.r1_o), 64'(e1));
         check("m_r4", 64'({bus4.r0_o, bus4.r1_o}), 64'({e0, e1}));
         m_we = 0;
         if (e0 || e1) begin
            addr    = e0 ? 32'(bus.a0_i) : 32'(bus.a1_i);
            data    = e0 ? bus.d0_i : bus.d1_i;
            m_we    = (addr != 0);
            m_waddr = addr;
            m_wdata = data;
            m_prio  = e0;
         end
         if (bus.v0_i && bus.v1_i && !bus.hold_i) begin
            if (m_conf < 65535) m_conf++;
            if (m_conf4 < 15) m_conf4++;
         end
      end
   end

   task automatic drive(input bit h, input bit v0, input int a0, input int d0,
                        input bit v1, input int a1, input int d1);
      @(posedge clk);
      #1;
      bus.hold_i = h;
      bus.v0_i = v0; bus.a0_i = 5'(a0); bus.d0_i = d0;
      bus.v1_i = v1; bus.a1_i = 5'(a1); bus.d1_i = d1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // single write
      do_reset();
      drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
      @(negedge clk);
      check("single_r0", 64'(bus.r0_o), 64'(1));
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("single_we", 64'(bus.we_o), 64'(1));
      check("single_waddr", 64'(bus.waddr_o), 64'(5));
      check("single_wdata", 64'(bus.wdata_o), 64'hDEADBEEF);
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("idle_we", 64'(bus.we_o), 64'(0));
      check("idle_waddr_hold", 64'(bus.waddr_o), 64'(5));

      // round robin
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 3, 32'h33, 1, 7, 32'h77);
         @(negedge clk);
         check("rr_r0", 64'(bus.r0_o), 64'(i % 2 == 0));
         check("rr_r1", 64'(bus.r1_o), 64'(i % 2 == 1));
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("rr_conf", 64'(bus.conflicts_o), 64'(4));
      check("rr_last_addr", 64'(bus.waddr_o), 64'(7));

      // x0 filter
      do_reset();
      drive(0, 0, 0, 0, 1, 0, 32'h1);
      @(negedge clk);
      check("x0_r1", 64'(bus.r1_o), 64'(1));
      drive(0, 1, 6, 32'h66, 1, 0, 32'h1);
      @(negedge clk);
      check("x0_we", 64'(bus.we_o), 64'(0));
      check("x0_prio_r0", 64'(bus.r0_o), 64'(1));

      // hold
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 2, 32'h22, 1, 3, 32'h33);
         @(negedge clk);
         check("hold_grants", 64'({bus.r0_o, bus.r1_o}), 64'(0));
         check("hold_we", 64'(bus.we_o), 64'(0));
      end
      drive(0, 1, 2, 32'h22, 1, 3, 32'h33);
      @(negedge clk);
      check("hold_conf", 64'(bus.conflicts_o), 64'(0));
      check("hold_release_r0", 64'(bus.r0_o), 64'(1));

      // saturation
      do_reset();
      for (int i = 0; i < 20; i++) drive(0, 1, 8, i, 1, 9, i + 100);
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("sat_conf4", 64'(bus4.conflicts_o), 64'hF);
      check("sat_conf16", 64'(bus.conflicts_o), 64'(20));

      // async reset between edges while a write is registered
      do_reset();
      drive(0, 1, 9, 32'h99, 1, 4, 32'h44);
      @(posedge clk);
      #1;
      check("async_pre_we", 64'(bus.we_o), 64'(1));
      check("async_pre_conf", 64'(bus.conflicts_o), 64'(1));
      rst = 1'b1;
      #1;
      check("async_we", 64'(bus.we_o), 64'(0));
      check("async_conf", 64'(bus.conflicts_o), 64'(0));
      check("async_grants", 64'({bus.r0_o, bus.r1_o}), 64'(0));
      #1;
      rst = 1'b0;
      #1;
      check("post_rst_r0", 64'(bus.r0_o), 64'(1));
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("post_rst_waddr", 64'(bus.waddr_o), 64'(9));
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
